// File: rtl/bc_spi_slave.sv
// SPI-slave (mode 0, MSB first) breadcrumb endpoint, oversampled in the clk domain.
// Optional BC_SPI_ERR_CNT_EN adds a saturating err_count output.
module bc_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_rdy,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_rdy,
  output logic        overrun
`ifdef BC_SPI_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
  logic        sck_s, cs_s, mosi_s, sck_prev;
  logic        sck_rise, sck_fall;
  logic [15:0] sout, sin;
  logic [3:0]  cnt;

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sr   <= '0;
      cs_sr    <= '1;
      mosi_sr  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_prev <= sck_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The 16th rise jumps straight to DONE, so it wins over a simultaneous deselect.
  always_comb begin
    state_nxt = state;
    tx_rdy    = 1'b0;
    case (state)
      S_IDLE:  if (!cs_s) state_nxt = S_LOAD;
      S_LOAD: begin
        if (cs_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SHIFT;
          tx_rdy    = tx_valid;
        end
      end
      S_SHIFT: begin
        if (sck_rise && cnt == 4'd15) state_nxt = S_DONE;
        else if (cs_s)                state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = cs_s ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Falls with cnt==0 are the trailing edge of the previous word and must not shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout     <= '0;
      sin      <= '0;
      cnt      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rx_valid && rx_rdy) rx_valid <= 1'b0;
      case (state)
        S_IDLE: cnt <= '0;
        S_LOAD: begin
          if (!cs_s) begin
            sout <= tx_valid ? tx_data : IDLE_WORD;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          if (sck_rise) begin
            sin <= {sin[14:0], mosi_s};
            cnt <= cnt + 4'd1;
          end else if (sck_fall && cnt != 4'd0) begin
            sout <= {sout[14:0], 1'b0};
          end
        end
        S_DONE: begin
          if (!rx_valid) begin
            rx_data  <= sin;
            rx_valid <= 1'b1;
          end else begin
            overrun  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign miso = (state == S_SHIFT || state == S_DONE) ? sout[15] : 1'b0;

`ifdef BC_SPI_ERR_CNT_EN
  logic err_evt;

  // Dropped word, aborted word, or a word started on IDLE_WORD.
  assign err_evt = (state == S_DONE && rx_valid) ||
                   ((state == S_LOAD || state == S_SHIFT) && state_nxt == S_IDLE) ||
                   (state == S_LOAD && !cs_s && !tx_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_count <= '0;
    else if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bc_spi_slave.sv
// Self-checking bench for bc_spi_slave: SPI host driver, FIFO models and scenario tasks.
module tb_bc_spi_slave;
  localparam int          SYNC = 2;
  localparam logic [15:0] IDLE = 16'h0000;
  localparam int          H    = 6;

  logic        clk = 0, rst = 1, sck = 0, cs_n = 1, mosi = 0, rx_rdy = 0;
  logic        miso, tx_rdy, rx_valid, overrun, tx_valid = 0;
  logic [15:0] tx_data = '0, rx_data;
`ifdef BC_SPI_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  bc_spi_slave #(.SYNC_STAGES(SYNC), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_rdy(tx_rdy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rdy(rx_rdy), .overrun(overrun)
`ifdef BC_SPI_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, pops = 0, tx_multi = 0, rx_rise_cyc = -1, last_rise_cyc = 0;
  int exp_err = 0;
  logic pop_req = 0, txr_prev = 0, rxv_prev = 0;
  logic [15:0] tx_fifo [$];
  logic [15:0] rx_got [$];
  logic [15:0] fw [4];
  logic [15:0] fm [4];
  int fn = 1, last_bits = 16;

  always @(posedge clk) cyc++;

  // Show-ahead outgoing FIFO model: pop lands just after the edge that saw tx_rdy.
  always begin
    @(posedge clk);
    #1;
    if (pop_req && tx_fifo.size() > 0) void'(tx_fifo.pop_front());
    pop_req  = 0;
    tx_valid = (tx_fifo.size() > 0);
    tx_data  = (tx_fifo.size() > 0) ? tx_fifo[0] : 16'h0000;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_rdy) begin
        pops++;
        pop_req = 1;
        if (txr_prev) tx_multi++;
      end
      if (rx_valid && rx_rdy) rx_got.push_back(rx_data);
      if (rx_valid && !rxv_prev) rx_rise_cyc = cyc;
    end
    txr_prev = tx_rdy;
    rxv_prev = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit end_cs,
                           output logic [15:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      mosi = w[15-i];
      tick(H);
      m[15-i] = miso;
      sck = 1;
      last_rise_cyc = cyc;
      if (i == n - 1 && end_cs) cs_n = 1;
      tick(H);
      sck = 0;
    end
  endtask

  // Host frame; the last full word deselects on the same cycle as its 16th rise.
  task automatic run_frame();
    int s;
    int bits;
    s = tx_fifo.size();
    if (fn > s) exp_err += fn - s;
    cs_n = 0;
    tick(8);
    for (int i = 0; i < fn; i++) begin
      bits = (i == fn - 1) ? last_bits : 16;
      send_bits(fw[i], bits, (i == fn - 1) && (bits == 16), fm[i]);
    end
    if (last_bits != 16) begin
      tick(2);
      cs_n = 1;
      exp_err++;
    end
    tick(12);
  endtask

  task automatic test_reset();
    tick(3);
    if (miso !== 1'b0)       begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++;
    if (tx_rdy !== 1'b0)     begin failures++; $display("FAIL reset_tx_rdy got=%b exp=0", tx_rdy); end
    checks++;
    if (rx_valid !== 1'b0)   begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++;
    if (rx_data !== 16'h0)   begin failures++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    checks++;
    if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++;
    rst = 0;
    tick(3);
  endtask

  task automatic test_single_word();
    pops = 0; rx_got.delete(); rx_rdy = 0; rx_rise_cyc = -1;
    tx_fifo.push_back(16'h1234);
    tick(3);
    fn = 1; last_bits = 16; fw[0] = 16'hA5C3;
    run_frame();
    if (fm[0] !== 16'h1234) begin failures++; $display("FAIL single_miso got=%h exp=1234", fm[0]); end
    checks++;
    if (pops !== 1)         begin failures++; $display("FAIL single_tx_pops got=%0d exp=1", pops); end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 16'hA5C3) begin
      failures++; $display("FAIL single_rx got=%b/%h exp=1/a5c3", rx_valid, rx_data);
    end
    checks++;
    if (rx_rise_cyc - last_rise_cyc !== SYNC + 2) begin
      failures++; $display("FAIL single_rx_latency got=%0d exp=%0d", rx_rise_cyc - last_rise_cyc, SYNC + 2);
    end
    checks++;
    rx_rdy = 1;
    tick(3);
    if (rx_valid !== 1'b0 || rx_got.size() != 1 || rx_got[0] !== 16'hA5C3) begin
      failures++; $display("FAIL single_handshake got=%b n=%0d exp=0 n=1", rx_valid, rx_got.size());
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] t0, t1;
    pops = 0; rx_got.delete(); rx_rdy = 1; tx_multi = 0;
    t0 = 16'($urandom); t1 = 16'($urandom);
    tx_fifo.push_back(t0); tx_fifo.push_back(t1);
    tick(3);
    fn = 2; last_bits = 16; fw[0] = 16'h0001; fw[1] = 16'h8000;
    run_frame();
    if (fm[0] !== t0 || fm[1] !== t1) begin
      failures++; $display("FAIL b2b_miso got=%h,%h exp=%h,%h", fm[0], fm[1], t0, t1);
    end
    checks++;
    if (rx_got.size() != 2 || rx_got[0] !== 16'h0001 || rx_got[1] !== 16'h8000) begin
      failures++; $display("FAIL b2b_rx_order n=%0d exp=2 words 0001,8000", rx_got.size());
    end
    checks++;
    if (pops !== 2 || tx_multi !== 0) begin
      failures++; $display("FAIL b2b_tx_pulses got=%0d multi=%0d exp=2 multi=0", pops, tx_multi);
    end
    checks++;
  endtask

  task automatic test_random();
    int npush;
    logic [15:0] pushed [4];
    logic [15:0] exp;
    rx_rdy = 1;
    for (int f = 0; f < 5; f++) begin
      pops = 0; rx_got.delete();
      fn = int'($urandom_range(1, 3)); last_bits = 16;
      npush = int'($urandom_range(0, fn));
      for (int i = 0; i < fn; i++) fw[i] = 16'($urandom);
      for (int i = 0; i < npush; i++) begin
        pushed[i] = 16'($urandom);
        tx_fifo.push_back(pushed[i]);
      end
      tick(3);
      run_frame();
      for (int i = 0; i < fn; i++) begin
        exp = (i < npush) ? pushed[i] : IDLE;
        if (fm[i] !== exp) begin failures++; $display("FAIL rand_miso f=%0d w=%0d got=%h exp=%h", f, i, fm[i], exp); end
        checks++;
        if (rx_got.size() <= i || rx_got[i] !== fw[i]) begin
          failures++; $display("FAIL rand_rx f=%0d w=%0d n=%0d exp=%h", f, i, rx_got.size(), fw[i]);
        end
        checks++;
      end
      if (pops !== npush) begin failures++; $display("FAIL rand_pops f=%0d got=%0d exp=%0d", f, pops, npush); end
      checks++;
    end
    if (overrun !== 1'b0) begin failures++; $display("FAIL rand_overrun got=%b exp=0", overrun); end
    checks++;
  endtask

  task automatic test_underrun();
    logic [15:0] w;
    pops = 0; rx_got.delete(); rx_rdy = 1;
    w = 16'($urandom);
    fn = 1; last_bits = 16; fw[0] = w;
    run_frame();
    if (fm[0] !== IDLE) begin failures++; $display("FAIL underrun_miso got=%h exp=%h", fm[0], IDLE); end
    checks++;
    if (pops !== 0)     begin failures++; $display("FAIL underrun_pops got=%0d exp=0", pops); end
    checks++;
    if (rx_got.size() != 1 || rx_got[0] !== w) begin
      failures++; $display("FAIL underrun_rx n=%0d exp=1 word %h", rx_got.size(), w);
    end
    checks++;
`ifdef BC_SPI_ERR_CNT_EN
    if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL underrun_err_count got=%0d exp=%0d", err_count, exp_err); end
    checks++;
`endif
  endtask

  task automatic test_abort();
    rx_got.delete(); rx_rdy = 1;
    fn = 1; last_bits = 7; fw[0] = 16'($urandom);
    run_frame();
    if (rx_valid !== 1'b0 || rx_got.size() != 0) begin
      failures++; $display("FAIL abort_no_rx got=%b n=%0d exp=0 n=0", rx_valid, rx_got.size());
    end
    checks++;
    if (miso !== 1'b0) begin failures++; $display("FAIL abort_idle_miso got=%b exp=0", miso); end
    checks++;
    last_bits = 16; fw[0] = 16'hBEEF;
    run_frame();
    if (rx_got.size() != 1 || rx_got[0] !== 16'hBEEF) begin
      failures++; $display("FAIL abort_next_word n=%0d exp=1 word beef", rx_got.size());
    end
    checks++;
`ifdef BC_SPI_ERR_CNT_EN
    if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL abort_err_count got=%0d exp=%0d", err_count, exp_err); end
    checks++;
`endif
  endtask

  task automatic test_overrun();
    rx_got.delete(); rx_rdy = 0;
    fn = 2; last_bits = 16; fw[0] = 16'h1111; fw[1] = 16'h2222;
    run_frame();
    exp_err++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h1111) begin
      failures++; $display("FAIL overrun_rx_data got=%b/%h exp=1/1111", rx_valid, rx_data);
    end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    checks++;
`ifdef BC_SPI_ERR_CNT_EN
    if (err_count !== 8'(exp_err)) begin failures++; $display("FAIL overrun_err_count got=%0d exp=%0d", err_count, exp_err); end
    checks++;
`endif
    rx_rdy = 1;
    tick(4);
    if (rx_got.size() != 1 || rx_got[0] !== 16'h1111 || overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_drain n=%0d ovr=%b exp=1 word 1111 ovr=1", rx_got.size(), overrun);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] m, t, r;
    rx_rdy = 0;
    tx_fifo.push_back(16'($urandom));
    tick(3);
    cs_n = 0;
    tick(8);
    send_bits(16'($urandom), 8, 1'b0, m);
    rst = 1;
    #1;
    if (miso !== 1'b0 || tx_rdy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 16'h0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got miso=%b txr=%b rxv=%b rxd=%h ovr=%b exp all 0",
               miso, tx_rdy, rx_valid, rx_data, overrun);
    end
    checks++;
`ifdef BC_SPI_ERR_CNT_EN
    if (err_count !== 8'h00) begin failures++; $display("FAIL midreset_err_count got=%0d exp=0", err_count); end
    checks++;
`endif
    exp_err = 0;
    cs_n = 1;
    tick(3);
    rst = 0;
    tx_fifo.delete();
    tick(3);
    pops = 0; rx_got.delete(); rx_rdy = 1;
    t = 16'($urandom); r = 16'($urandom);
    tx_fifo.push_back(t);
    tick(3);
    fn = 1; last_bits = 16; fw[0] = r;
    run_frame();
    if (fm[0] !== t || rx_got.size() != 1 || rx_got[0] !== r) begin
      failures++; $display("FAIL midreset_next got miso=%h n=%0d exp miso=%h word %h", fm[0], rx_got.size(), t, r);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random();
    test_underrun();
    test_abort();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bc_spi_slave.md
# bc_spi_slave

SPI-slave link endpoint that carries 16-bit breadcrumb words between the external avoidance host and the breadcrumb FIFOs. Received MOSI words are presented on a ready/valid output that feeds the incoming breadcrumb FIFO write side. Words popped from the outgoing breadcrumb FIFO through a ready/valid input are shifted out on MISO. SPI pins are oversampled in the `clk` domain, so the block has no logic clocked by `sck`.

## Interface
- `SYNC_STAGES`, 2, synchronizer depth on `sck`, `cs_n`, `mosi` (minimum 2).
- `IDLE_WORD`, 16'h0000, word shifted out when no TX word is available at word start.
- `clk  in  1`  system clock; all logic is on the rising edge.
- `rst  in  1`  reset, asynchronous and active-high.
- `sck  in  1`  SPI clock from the host. Mode 0 (CPOL=0, CPHA=0), MSB first.
- `cs_n  in  1`  SPI chip select, active-low.
- `mosi  in  1`  serial data from the host.
- `miso  out  1`  serial data to the host. Driven only while the block is selected; 0 otherwise.
- `tx_data  in  16`  next outgoing word, from the outgoing FIFO `dout`.
- `tx_valid  in  1`  outgoing FIFO not empty.
- `tx_rdy  out  1`  one-cycle pop strobe to the outgoing FIFO `rd_en`.
- `rx_data  out  16`  last received word.
- `rx_valid  out  1`  `rx_data` is valid; held until accepted.
- `rx_rdy  in  1`  incoming FIFO not full.
- `overrun  out  1`  sticky flag: a received word was dropped. Cleared only by `rst`.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edges are detected by comparing the last synchronized sample with the previous one.
- FSM states:
  - IDLE: wait for `cs_n` low, then go to LOAD.
  - LOAD: one cycle. If `tx_valid`=1, capture `tx_data` into the shift-out register and pulse `tx_rdy`. Otherwise capture `IDLE_WORD` and leave `tx_rdy`=0. Bit counter := 0. Go to SHIFT.
  - SHIFT:
    - On an `sck` rising edge, shift `mosi` into the shift-in register and increment the counter.
    - On an `sck` falling edge, shift the shift-out register left. `miso` always equals shift-out bit 15.
    - When the counter reaches 16, go to DONE.
  - DONE: one cycle.
    - If `rx_valid`=0, set `rx_data` := shift-in and `rx_valid` := 1.
    - Else set `overrun` := 1 and drop the word.
    - Go to LOAD if `cs_n` is still low, else IDLE. Several words per frame are therefore supported.
- Handshake: `rx_valid` falls the cycle after `rx_valid`&`rx_rdy` is sampled high. `rx_data` is stable while `rx_valid`=1.
- `cs_n` deasserting in LOAD or SHIFT aborts the word:
  - partial bits are discarded;
  - `rx_valid` is unchanged;
  - a TX word already popped is lost;
  - FSM goes to IDLE.
- A 16th rising edge coinciding with `cs_n` deassertion in the same cycle completes the word (DONE has priority).
- `rst` mid-transfer returns the block to IDLE immediately and discards all state.
- Reset values: `miso`=0, `tx_rdy`=0, `rx_valid`=0, `rx_data`=0, `overrun`=0, FSM=IDLE, counters 0.

## Timing
- Host constraints:
  - `sck` high and low phases ≥ (`SYNC_STAGES`+2) `clk` periods.
  - First `sck` rise ≥ (`SYNC_STAGES`+3) `clk` after `cs_n` fall.
  - Gap between word 16th rise and next word's first rise ≥ (`SYNC_STAGES`+4) `clk`.
- `miso` MSB is valid `SYNC_STAGES`+2 cycles after raw `cs_n` fall.
- `rx_valid` asserts `SYNC_STAGES`+2 cycles after the raw 16th `sck` rise.
- `tx_rdy` is a single-cycle pulse, issued at most once per word.

## Configuration
- `BC_SPI_ERR_CNT_EN`, when defined:
  - adds output `err_count  out  8`;
  - the counter saturates at 8'hFF;
  - it increments on each dropped RX word, each aborted word, and each word started with `IDLE_WORD` (TX underrun);
  - reset value 0.
- When undefined, the port and counter are absent. `overrun` behaviour is identical in both builds.

## Test plan
- Single word: `cs_n` low, host sends 16'hA5C3 while `tx_data`=16'h1234 and `tx_valid`=1 -> one `tx_rdy` pulse, MISO carries 16'h1234 MSB first, `rx_data`=16'hA5C3 and `rx_valid`=1 until `rx_rdy`.
- Back-to-back: two words 16'h0001 and 16'h8000 in one frame with `rx_rdy`=1 -> two `rx_valid` handshakes in order, two `tx_rdy` pulses.
- Underrun: `tx_valid`=0 with `IDLE_WORD`=16'h0000 -> MISO all zeros, no `tx_rdy`, RX still delivered; `err_count`=1 when `BC_SPI_ERR_CNT_EN` is defined.
- Overrun: `rx_rdy`=0, send 16'h1111 then 16'h2222 -> `rx_data` stays 16'h1111, `overrun`=1.
- Abort: raise `cs_n` after 7 bits -> no `rx_valid`, FSM in IDLE; next full word 16'hBEEF received correctly.
- Async reset asserted mid-word -> all outputs return to reset values within the same cycle; next transfer works normally.
